// File: rtl/op_ctrl_pkg.sv
// Shared definitions for the op_issue_ctrl slice: FSM state encoding and
// default parameter values.
package op_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } op_state_e;

  localparam int ID_W_DEF    = 4;
  localparam int TIMEOUT_DEF = 16;
  localparam int TMR_W_DEF   = 5;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/op_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module op_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/op_issue_ctrl.sv
// Issues one tagged operation at a time to the latency counter (op_en/op_done),
// guards it with a watchdog and returns a tagged response with an error flag.
module op_issue_ctrl
  import op_ctrl_pkg::*;
#(
  parameter int ID_W    = ID_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TMR_W   = TMR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [ID_W-1:0]  req_id,
  output logic             req_ready,
  output logic             op_en,
  input  logic             op_done,
  output logic             resp_valid,
  output logic [ID_W-1:0]  resp_id,
  output logic             resp_err,
  input  logic             resp_ready,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  op_state_e        state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             err_q, err_d;
  logic             req_ready_q, req_ready_d;
  logic             op_en_q, op_en_d;
  logic             resp_valid_q, resp_valid_d;
  logic             done_inc, err_inc;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    id_d     = id_q;
    err_d    = err_q;
    done_inc = 1'b0;
    err_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        // req_ready_q gates acceptance so nothing is taken while reset releases
        if (req_valid && req_ready_q) begin
          id_d    = req_id;
          tmr_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (op_done) begin
          err_d    = 1'b0;
          done_inc = 1'b1;
          state_d  = RESP;
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          err_inc = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state: no input-to-output path.
    req_ready_d  = (state_d == IDLE);
    op_en_d      = (state_d == BUSY);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      op_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      id_q         <= id_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      op_en_q      <= op_en_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign op_en      = op_en_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_err   = err_q;

  op_sat_cnt #(.W(CNT_W)) u_done_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (done_inc),
    .clr   (stat_clr),
    .cnt   (done_cnt)
  );

  op_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (err_inc),
    .clr   (stat_clr),
    .cnt   (err_cnt)
  );

endmodule

// File: doc/op_issue_ctrl.md
# op_issue_ctrl

Initiator side of the `countEN`/`op_done` completion interface used by the change-in-y integration datapath. It accepts tagged operation requests over a valid/ready handshake and asserts `op_en` to the latency counter. It waits for `op_done`, then returns a tagged response with an error flag on watchdog timeout. It also keeps saturating statistics counters for completed and timed-out operations.

## Interface
Parameters:
- `ID_W`, 4: width of the request/response tag.
- `TIMEOUT`, 16: maximum BUSY cycles before the operation is aborted; legal range 2..2^TMR_W-1.
- `TMR_W`, 5: width of the watchdog timer.
- `CNT_W`, 8: width of each statistics counter.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_id`  in  ID_W  request tag.
- `req_ready`  out  1  block can accept a request.
- `op_en`  out  1  enable to the latency counter; drives its `countEN`.
- `op_done`  in  1  completion pulse from the latency counter.
- `resp_valid`  out  1  response present.
- `resp_id`  out  ID_W  tag of the completed request.
- `resp_err`  out  1  operation ended by timeout, not by `op_done`.
- `resp_ready`  in  1  consumer accepts the response.
- `stat_clr`  in  1  synchronous clear of both statistics counters.
- `done_cnt`  out  CNT_W  operations completed by `op_done`; saturating.
- `err_cnt`  out  CNT_W  operations ended by timeout; saturating.

## Operation
- FSM states: IDLE, BUSY, RESP. All outputs are registered or decoded from the state only, with no combinational path from inputs to outputs.
- IDLE: `req_ready`=1. When `req_valid`=1, the block latches `req_id`, clears the timer, and moves to BUSY.
- BUSY: `op_en`=1 and the timer increments each cycle.
  - If `op_done`=1, go to RESP with `resp_err`=0 and increment `done_cnt`.
  - Otherwise, if timer = TIMEOUT-1, go to RESP with `resp_err`=1 and increment `err_cnt`.
  - If `op_done` and the timeout condition occur in the same cycle, `op_done` wins.
- RESP: `op_en`=0 and `resp_valid`=1. `resp_id` and `resp_err` are held stable until `resp_ready`=1, then the FSM returns to IDLE.
- `req_ready` is 0 in BUSY and RESP. There is no bypass; a new request is accepted only from IDLE.
- `op_done` is ignored outside BUSY. A spurious pulse has no effect on the FSM or on the counters.
- Statistics counters saturate at 2^CNT_W-1 and never wrap.
- `stat_clr` zeroes both counters. If it coincides with an increment, the clear wins.
- Dropping `op_en` for at least one cycle between operations re-arms the latency counter to its initial value.

## Timing
- Reset (async assert, sync release): state=IDLE, `op_en`=0, `req_ready`=0 during reset and 1 from the first cycle after release. Also `resp_valid`=0, `resp_id`=0, `resp_err`=0, timer=0, `done_cnt`=0, `err_cnt`=0.
- Reset mid-operation discards the pending request, and no response is produced for it. Reset also takes `op_en` low immediately, which re-arms the latency counter.
- Latency with the 3-shift latency counter:
  - `op_en` rises in the cycle after the accepting edge.
  - `op_done` is high in the 4th BUSY cycle.
  - `resp_valid` rises 4 cycles after the accepting edge.
- Timeout: `resp_valid` with `resp_err`=1 rises TIMEOUT cycles after the accepting edge.
- If `resp_ready` is already 1 when `resp_valid` rises, the response completes in one cycle. IDLE is re-entered on the next edge.
- Maximum throughput is one operation per 6 cycles (accept, 4 BUSY, 1 RESP).

## Structure
- Shared package `op_ctrl_pkg` holds:
  - the state enum (IDLE, BUSY, RESP);
  - default values for ID_W, TIMEOUT, TMR_W, CNT_W.
- Sub-module `op_sat_cnt` is a parameterised-width saturating counter with `inc` and `clr` inputs, instantiated twice for `done_cnt` and `err_cnt`.
- The watchdog timer and the FSM stay inline.

## Test plan
- Normal op, with the latency counter attached: req_id=4'hA accepted.
  - Required: `op_en` high for 4 cycles; `resp_valid`=1 with `resp_id`=A and `resp_err`=0 exactly 4 cycles after accept; `done_cnt`=1.
- Timeout: `op_done` tied 0, TIMEOUT=16, req_id=3.
  - Required: `resp_valid` with `resp_err`=1 and `resp_id`=3 at 16 cycles; `err_cnt`=1; `done_cnt`=0.
- Backpressure: `resp_ready`=0 for 10 cycles, with `req_valid` held high carrying a new id.
  - Required: `req_ready`=0 throughout; `resp_id` and `resp_err` stable; `op_en`=0; the second request is accepted only after the response handshake.
- Simultaneous events:
  - `op_done` on the same cycle as the timeout → `resp_err`=0.
  - `op_done` pulse in IDLE → no state change and no counter change.
  - `stat_clr` together with completion → both counters read 0.
- Reset mid-BUSY (2nd BUSY cycle) → `op_en`=0 and `resp_valid`=0 asynchronously. After release, a new op completes with normal 4-cycle latency.
- Saturation: CNT_W=2, 5 completed ops → `done_cnt` holds at 3.
